// File: rtl/freq_div_multi.sv
// -----------------------------------------------------------------------------
// freq_div_multi
//
// Purpose:
//   CHANNELS independent programmable clock dividers running from one clock.
//   Each channel counts 0..div-1 while enabled and emits a one-cycle tick on
//   every wrap. fdiv is either a 50% square wave (toggles on each wrap) or a
//   copy of tick (pulse mode). A new divide value and mode can be written at
//   any time through a valid/ready port. The write is held in a shadow
//   register and applied on the channel's next wrap, so periods are never
//   truncated.
//
// Parameters:
//   CHANNELS    number of divider channels (1..16)
//   WIDTH       divide-value / counter width
//   DEFAULT_DIV divide value loaded into every channel at reset
//
// Ports:
//   clk        in   clock, all logic on its rising edge
//   rst        in   asynchronous active-low reset
//   en         in   [CHANNELS] per-channel run enable
//   sync       in   (only with FREQ_DIV_MULTI_SYNC_EN) realign all channels
//   cfg_valid  in   configuration write request
//   cfg_ready  out  configuration write can be accepted
//   cfg_chan   in   [CW] target channel
//   cfg_div    in   [WIDTH] new divide value
//   cfg_mode   in   0 = square output, 1 = pulse output
//   fdiv       out  [CHANNELS] divided output, registered
//   tick       out  [CHANNELS] one-cycle wrap strobe, registered
//
// Optional feature:
//   Define FREQ_DIV_MULTI_SYNC_EN to add the sync input. A sync sampled high
//   clears every counter and output and applies all pending updates on that
//   edge, which brings all channels back into phase. Without the macro the
//   channels are free-running and independent.
//
// Handshake:
//   A write transfers on the rising edge where cfg_valid && cfg_ready. The
//   ready signal is combinational: it is low only while the addressed channel
//   already holds an unapplied update. Writes to a channel number at or above
//   CHANNELS always see ready high and are discarded.
// -----------------------------------------------------------------------------
module freq_div_multi #(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 24,
    parameter  int DEFAULT_DIV = 800000,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
`ifdef FREQ_DIV_MULTI_SYNC_EN
    input  logic                sync,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] fdiv,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam int               NSLOT   = 1 << CW;

    logic [CHANNELS-1:0] w_pend;
    logic [NSLOT-1:0]    w_pend_slot;
    logic                w_accept;
    logic                w_sync;

`ifdef FREQ_DIV_MULTI_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Channel numbers that do not exist read as "not pending", so such writes
    // always complete immediately and then go nowhere.
    always_comb begin
        w_pend_slot                = '0;
        w_pend_slot[CHANNELS-1:0]  = w_pend;
    end

    assign cfg_ready = ~w_pend_slot[cfg_chan];
    assign w_accept  = cfg_valid & cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_sh_div;
        logic             r_mode;
        logic             r_sh_mode;
        logic             r_pend;
        logic             r_fdiv;
        logic             r_tick;

        logic             w_wr;
        logic             w_run;
        logic             w_wrap;
        logic             w_apply;
        logic             w_new_mode;
        logic             w_fdiv_wrap;

        assign w_wr   = w_accept && (cfg_chan == CW'(i));
        assign w_run  = en[i] && (r_div != '0);
        assign w_wrap = w_run && (r_cnt == r_div - WIDTH'(1));

        // A stopped channel has no wrap to wait for, so its update lands on
        // the first edge after it was written. A write can only be accepted
        // while r_pend is low, so it never collides with its own apply.
        assign w_apply = r_pend && (w_sync || !w_run || w_wrap);

        // fdiv on a wrap edge: pulse mode (new) follows tick; square mode
        // toggles, except that leaving pulse mode restarts the square at 0.
        assign w_new_mode  = w_apply ? r_sh_mode : r_mode;
        assign w_fdiv_wrap = w_new_mode ? 1'b1 : (r_mode ? 1'b0 : ~r_fdiv);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt     <= '0;
                r_div     <= DIV_RST;
                r_sh_div  <= DIV_RST;
                r_mode    <= 1'b0;
                r_sh_mode <= 1'b0;
                r_pend    <= 1'b0;
                r_fdiv    <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_sh_div  <= cfg_div;
                    r_sh_mode <= cfg_mode;
                    r_pend    <= 1'b1;
                end else if (w_apply) begin
                    r_pend    <= 1'b0;
                end

                if (w_apply) begin
                    r_div  <= r_sh_div;
                    r_mode <= r_sh_mode;
                end

                // sync has priority over a wrap on the same edge.
                if (w_sync || !w_run) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_fdiv <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_fdiv <= w_fdiv_wrap;
                end else begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_tick <= 1'b0;
                    if (r_mode) begin
                        r_fdiv <= 1'b0;
                    end
                end
            end
        end

        assign w_pend[i] = r_pend;
        assign fdiv[i]   = r_fdiv;
        assign tick[i]   = r_tick;
    end

endmodule

// File: tb/tb_freq_div_multi.sv
module tb_freq_div_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: CHANNELS=4, WIDTH=8, DEFAULT_DIV=4
  logic       rst = 1'b0;
  logic [3:0] en = '0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_mode = 1'b0;
  wire        cfg_ready;
  wire  [3:0] fdiv;
  wire  [3:0] tick;

  // second instance with 5 channels so that channel number 5 is encodable
  logic [4:0] en5 = '0;
  logic       cfg_valid5 = 1'b0;
  logic [2:0] cfg_chan5 = '0;
  logic [7:0] cfg_div5 = '0;
  logic       cfg_mode5 = 1'b0;
  wire        cfg_ready5;
  wire  [4:0] fdiv5;
  wire  [4:0] tick5;

`ifdef FREQ_DIV_MULTI_SYNC_EN
  logic sync = 1'b0;
  logic sync5 = 1'b0;
`endif

  freq_div_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef FREQ_DIV_MULTI_SYNC_EN
    .sync(sync),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .fdiv(fdiv), .tick(tick)
  );

  freq_div_multi #(.CHANNELS(5), .WIDTH(8), .DEFAULT_DIV(4)) u_dut5 (
    .clk(clk), .rst(rst), .en(en5),
`ifdef FREQ_DIV_MULTI_SYNC_EN
    .sync(sync5),
`endif
    .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5), .cfg_chan(cfg_chan5),
    .cfg_div(cfg_div5), .cfg_mode(cfg_mode5), .fdiv(fdiv5), .tick(tick5)
  );

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // expected {fdiv,tick} image of the 4-channel instance for one channel
  function automatic logic [15:0] pk(int ch, logic f, logic t);
    logic [15:0] v;
    v = '0;
    v[4+ch] = f;
    v[ch] = t;
    return v;
  endfunction

  // leaves time at posedge+2 with rst released; next posedge is edge 1
  task automatic do_reset();
    rst = 1'b0;
    en = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_mode = 1'b0;
    en5 = '0; cfg_valid5 = 1'b0; cfg_chan5 = '0; cfg_div5 = '0; cfg_mode5 = 1'b0;
`ifdef FREQ_DIV_MULTI_SYNC_EN
    sync = 1'b0; sync5 = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b0;
    en = 4'hF;
    @(posedge clk); #1;
    got = {8'h00, fdiv, tick};
    n_vec++;
    if (got !== 16'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", got, 16'h0);
    end
    for (int c = 0; c < 4; c++) begin
      cfg_chan = c[1:0]; #1;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
        n_err++; $display("FAIL reset_ready chan %0d: got %b want 1", c, cfg_ready);
      end
    end
    en = '0;
    #1 rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(16'h0);
      @(posedge clk); #1;
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== exp_q[0]) begin
        n_err++; $display("FAIL idle_disabled edge %0d: got %h want %h", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_square();
    logic [15:0] got, e;
    logic t, f;
    do_reset();
    en = 4'b0001;
    for (int k = 1; k <= 24; k++) begin
      t = (k % 4 == 0);
      f = ((k / 4) % 2 == 1);
      exp_q.push_back(pk(0, f, t));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL square_ch0 edge %0d: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [15:0] got, e;
    logic t;
    do_reset();
    en = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        cfg_chan = 2'd1; cfg_div = 8'd3; cfg_mode = 1'b1; cfg_valid = 1'b1;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL reconfig_ready_idle: got %b want 1", cfg_ready);
        end
      end
      t = (k >= 4) && ((k - 4) % 3 == 0);
      exp_q.push_back(pk(1, t, t) | pk(1, (k == 4), 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL reconfig_ch1 edge %0d: got %h want %h", k, got, e);
      end
      if (k == 3) begin
        cfg_valid = 1'b0; #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
          n_err++; $display("FAIL reconfig_ready_pending: got %b want 0", cfg_ready);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL reconfig_ready_applied: got %b want 1", cfg_ready);
        end
      end
    end
  endtask

  task automatic test_div0_div1();
    logic [15:0] got, e;
    logic t, f;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin
        cfg_chan = 2'd2; cfg_div = 8'd0; cfg_mode = 1'b0; cfg_valid = 1'b1;
      end
      if (k == 3) en = 4'b0100;
      if (k == 11) begin
        cfg_chan = 2'd2; cfg_div = 8'd1; cfg_mode = 1'b0; #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
          n_err++; $display("FAIL div0_ready: got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
      end
      t = (k >= 13);
      f = (k >= 13) && ((k - 13) % 2 == 0);
      exp_q.push_back(pk(2, f, t));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL div0_div1_ch2 edge %0d: got %h want %h", k, got, e);
      end
      if (k == 1 || k == 11) cfg_valid = 1'b0;
      if (k == 11) begin
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
          n_err++; $display("FAIL div1_ready_pending: got %b want 0", cfg_ready);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got, e;
    logic t, f;
    do_reset();
    en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin
        cfg_chan = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b1; cfg_valid = 1'b1;
      end
      exp_q.push_back(pk(0, (k >= 4), (k == 4)));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL pre_reset_ch0 edge %0d: got %h want %h", k, got, e);
      end
      if (k == 5) begin
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
          n_err++; $display("FAIL pre_reset_pending: got %b want 0", cfg_ready);
        end
      end
    end
    #1 rst = 1'b0;
    #1;
    got = {8'h00, fdiv, tick};
    n_vec++;
    if (got !== 16'h0) begin
      n_err++; $display("FAIL async_reset_outputs: got %h want %h", got, 16'h0);
    end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset_ready: got %b want 1", cfg_ready);
    end
    #1 rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      t = (k % 4 == 0);
      f = ((k / 4) % 2 == 1);
      exp_q.push_back(pk(0, f, t));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL post_reset_ch0 edge %0d: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] got, e;
    logic t, f;
    do_reset();
    en5 = 5'b11111;
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) begin
        cfg_chan5 = 3'd5; cfg_div5 = 8'($urandom_range(1, 3)); cfg_mode5 = 1'b1;
        cfg_valid5 = 1'b1; #1;
        n_vec++;
        if (cfg_ready5 !== 1'b1) begin
          n_err++; $display("FAIL oor_ready: got %b want 1", cfg_ready5);
        end
      end
      t = (k % 4 == 0);
      f = ((k / 4) % 2 == 1);
      exp_q.push_back({6'h00, {5{f}}, {5{t}}});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {6'h00, fdiv5, tick5};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL oor_timing edge %0d: got %h want %h", k, got, e);
      end
      if (k == 2) begin
        cfg_valid5 = 1'b0;
        for (int c = 0; c < 5; c++) begin
          cfg_chan5 = c[2:0]; #1;
          n_vec++;
          if (cfg_ready5 !== 1'b1) begin
            n_err++; $display("FAIL oor_no_pending chan %0d: got %b want 1", c, cfg_ready5);
          end
        end
      end
    end
  endtask

`ifdef FREQ_DIV_MULTI_SYNC_EN
  task automatic test_sync();
    logic [15:0] got, e;
    int pre;
    do_reset();
    cfg_chan = 2'd0; cfg_div = 8'd5; cfg_mode = 1'b0; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_chan = 2'd2; cfg_div = 8'd7;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    en = 4'b0101;
    pre = $urandom_range(1, 6);
    repeat (pre) begin
      @(posedge clk); #1;
    end
    sync = 1'b1;
    exp_q.push_back(16'h0);
    @(posedge clk); #1;
    sync = 1'b0;
    e = exp_q.pop_front();
    got = {8'h00, fdiv, tick};
    n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL sync_edge: got %h want %h", got, e);
    end
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(pk(0, ((k / 5) % 2 == 1), (k % 5 == 0)) |
                      pk(2, ((k / 7) % 2 == 1), (k % 7 == 0)));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      got = {8'h00, fdiv, tick};
      n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL sync_realign edge %0d: got %h want %h", k, got, e);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_square();
    test_reconfig();
    test_div0_div1();
    test_async_reset();
    test_out_of_range();
`ifdef FREQ_DIV_MULTI_SYNC_EN
    test_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
